// File: rtl/pc_fetch.sv
// pc_fetch: PC register and imem req/ack fetch sequencer for decode; PC_ALIGN_CHECK_EN enables niaddr word-alignment forcing
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      niaddr,
  input  logic             stall,
  input  logic             instr_ready,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      iaddr,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             fetch_misalign
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx;
  logic capture, accept, misalign;
  assign capture = state == REQ && imem_ack;
  assign accept = state == HOLD && instr_ready && !stall;
`ifdef PC_ALIGN_CHECK_EN
  assign pc_nx = {niaddr[31:2], 2'b00};
  assign misalign = niaddr[1:0] != 2'b00;
`else
  assign pc_nx = niaddr;
  assign misalign = 1'b0;
`endif
  assign imem_req = state == REQ;
  assign imem_addr = pc;
  assign iaddr = pc;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? REQ : capture ? HOLD : accept ? REQ : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      instr <= 32'h0;
      instr_valid <= 1'b0;
      retire_cnt <= '0;
      fetch_misalign <= 1'b0;
    end else if (capture) begin
      instr <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (accept) begin
      pc <= pc_nx;
      instr_valid <= 1'b0;
      retire_cnt <= retire_cnt + CNT_W'(1);
      fetch_misalign <= fetch_misalign | misalign;
    end
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scoreboard bench for pc_fetch
module tb_pc_fetch;
  logic clk = 1'b0;
  logic rst, stall, instr_ready, imem_ack;
  logic [31:0] niaddr, imem_rdata;
  logic imem_req, instr_valid, fetch_misalign;
  logic [31:0] imem_addr, iaddr, instr, retire_cnt;
  logic [31:0] sb[$];
  int n_asrt = 0, n_fail = 0;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_PC = 32'h3004;
  localparam logic [31:0] MIS_FLAG = 32'h1;
`else
  localparam logic [31:0] MIS_PC = 32'h3006;
  localparam logic [31:0] MIS_FLAG = 32'h0;
`endif

  pc_fetch dut (
    .clk(clk), .rst(rst), .niaddr(niaddr), .stall(stall), .instr_ready(instr_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .iaddr(iaddr), .instr(instr), .instr_valid(instr_valid), .retire_cnt(retire_cnt),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack_word(input logic [31:0] w);
    imem_ack = 1'b1;
    imem_rdata = w;
    sb.push_back(w);
    step();
    imem_ack = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'h0, 32'h1);
    else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr, e);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; instr_ready = 1'b0; imem_ack = 1'b0;
    niaddr = 32'h0; imem_rdata = 32'h0;
    step(); step();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_pc", iaddr, 32'h3000);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_cnt", retire_cnt, 32'h0);
    chk("rst_mis", {31'h0, fetch_misalign}, 32'h0);
    rst = 1'b0;
    step();
    chk("t1_req", {31'h0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h3000);
    ack_word(32'h2008_0005);
    chk("t1_valid_next", {31'h0, instr_valid}, 32'h1);
    pop_chk("t1");
    chk("t1_iaddr", iaddr, 32'h3000);
    stall = 1'b1; instr_ready = 1'b1; niaddr = 32'h3004;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_pc", iaddr, 32'h3000);
      chk("t3_instr", instr, 32'h2008_0005);
      chk("t3_cnt", retire_cnt, 32'h0);
    end
    stall = 1'b0;
    step();
    instr_ready = 1'b0;
    chk("t3_pc_after", iaddr, 32'h3004);
    chk("t3_cnt_after", retire_cnt, 32'h1);
    chk("t3_valid_drop", {31'h0, instr_valid}, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", {31'h0, imem_req}, 32'h1);
      chk("t2_addr", imem_addr, 32'h3004);
      chk("t2_novalid", {31'h0, instr_valid}, 32'h0);
      if (i < 3) step();
    end
    stall = 1'b0;
    ack_word(32'h8C08_0004);
    pop_chk("t2");
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t6_hold_instr", instr, 32'h8C08_0004);
      chk("t6_hold_req", {31'h0, imem_req}, 32'h0);
      chk("t6_hold_valid", {31'h0, instr_valid}, 32'h1);
    end
    imem_ack = 1'b0;
    niaddr = 32'h3006; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t5_pc", iaddr, MIS_PC);
    chk("t5_mis", {31'h0, fetch_misalign}, MIS_FLAG);
    chk("t5_cnt", retire_cnt, 32'h2);
    ack_word(32'h0000_0000);
    pop_chk("t5");
    niaddr = 32'h3010; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t5_mis_sticky", {31'h0, fetch_misalign}, MIS_FLAG);
    chk("t5_pc2", iaddr, 32'h3010);
    chk("t4_in_req", {31'h0, imem_req}, 32'h1);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    rst = 1'b0;
    chk("t4_rst_req", {31'h0, imem_req}, 32'h0);
    chk("t4_rst_pc", iaddr, 32'h3000);
    chk("t4_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("t4_rst_cnt", retire_cnt, 32'h0);
    chk("t4_rst_mis", {31'h0, fetch_misalign}, 32'h0);
    step();
    imem_ack = 1'b0;
    chk("t4_late_valid", {31'h0, instr_valid}, 32'h0);
    chk("t4_late_instr", instr, 32'h0);
    chk("t4_restart_req", {31'h0, imem_req}, 32'h1);
    chk("t4_restart_addr", imem_addr, 32'h3000);
    step();
    ack_word(32'h3C01_1234);
    pop_chk("t4");
    niaddr = 32'hFFFF_FFFC; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("wrap_pc_hi", iaddr, 32'hFFFF_FFFC);
    ack_word(32'h0800_0C00);
    pop_chk("wrap");
    niaddr = 32'h0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("wrap_pc_zero", iaddr, 32'h0);
    chk("wrap_cnt", retire_cnt, 32'h2);
    chk("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
